dcache_ctrl: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate data cache for the five-stage pipelined core. It sits between the MEM stage and a slow off-chip data memory that uses a req/ack handshake. Hits complete in the requesting cycle. Misses freeze the whole pipeline through `stall_o` until the line has been written back, if needed, and refilled. It also keeps saturating hit/miss counters for performance runs.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_array.sv | 65 ++++++
 rtl/dcache_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
//   dcache_state_e : controller FSM states
//   off_w/idx_w/tag_w : address-field widths derived from the cache geometry
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE,
    ST_REFILL
  } dcache_state_e;

  function automatic int unsigned off_w(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned line_w,
                                        input int unsigned num_lines);
    return addr_w - off_w(line_w) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache.
// Ports:
//   clk, rst            : clock, async active-high clear of valid/dirty
//   idx                 : line index shared by read and write
//   rd_valid/rd_dirty/rd_tag/rd_line : asynchronous read of the indexed line
//   word_we/word_sel/word_data       : single-word write into the indexed line
//   line_we/line_tag/line_data       : whole-line refill (sets valid, clears dirty)
//   dirty_we/dirty_val               : set/clear dirty of the indexed line
module dcache_array #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned TAG_W     = 22,
  parameter int unsigned WSEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [DATA_W-1:0] word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              dirty_we,
  input  logic              dirty_val
);

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [LINE_W-1:0]    data [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (dirty_we) begin
      dirty[idx] <= dirty_val;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx] <= line_tag;
      data[idx] <= line_data;
    end else if (word_we) begin
      data[idx][word_sel*DATA_W +: DATA_W] <= word_data;
    end
  end

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally; misses stall the pipeline while the victim
// line is written back (if dirty) and the new line is fetched.
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   req_i/we_i/addr_i/wdata_i : MEM-stage access (held stable while stalled)
//   rdata_o, stall_o    : load data and pipeline freeze
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : registered off-chip request
//   mem_rdata_i/mem_ack_i : off-chip response (one-cycle ack)
//   hit_cnt_o/miss_cnt_o : saturating performance counters
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int unsigned OFF_W  = off_w(LINE_W);
  localparam int unsigned IDX_W  = idx_w(NUM_LINES);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, LINE_W, NUM_LINES);
  localparam int unsigned WSEL_W = OFF_W - 2;

  dcache_state_e state, state_n;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              unused_byte_sel;

  logic              line_valid, line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic [LINE_W-1:0] refill_q;

  logic hit, word_we, line_we, dirty_we, dirty_val, hit_evt, miss_evt;

  assign idx             = addr_i[OFF_W +: IDX_W];
  assign tag             = addr_i[ADDR_W-1 -: TAG_W];
  assign wsel            = addr_i[OFF_W-1:2];
  assign unused_byte_sel = ^addr_i[1:0];

  dcache_array #(
    .DATA_W   (DATA_W),
    .LINE_W   (LINE_W),
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .WSEL_W   (WSEL_W)
  ) u_array (
    .clk      (clk_i),
    .rst      (rst_i),
    .idx      (idx),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_line  (line_data),
    .word_we  (word_we),
    .word_sel (wsel),
    .word_data(wdata_i),
    .line_we  (line_we),
    .line_tag (tag),
    .line_data(refill_q),
    .dirty_we (dirty_we),
    .dirty_val(dirty_val)
  );

  assign hit     = req_i & line_valid & (line_tag == tag);
  assign rdata_o = line_data[wsel*DATA_W +: DATA_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    stall_o   = 1'b0;
    word_we   = 1'b0;
    line_we   = 1'b0;
    dirty_we  = 1'b0;
    dirty_val = 1'b0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_i) begin
          if (hit) begin
            hit_evt = 1'b1;
            if (we_i) begin
              word_we   = 1'b1;
              dirty_we  = 1'b1;
              dirty_val = 1'b1;
            end
          end else begin
            stall_o  = 1'b1;
            miss_evt = 1'b1;
            state_n  = (line_valid & line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        stall_o = 1'b1;
        if (mem_ack_i) state_n = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        stall_o = 1'b1;
        if (mem_ack_i) state_n = ST_REFILL;
      end
      ST_REFILL: begin
        stall_o = 1'b1;
        line_we = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request registers load on the transition into WRITEBACK/ALLOCATE so the
  // request is visible in the first cycle of that state; a writeback ack
  // rolls straight into the fetch without dropping mem_req_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (state == ST_IDLE && state_n == ST_WRITEBACK) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= 1'b1;
      mem_addr_o  <= {line_tag, idx, {OFF_W{1'b0}}};
      mem_wdata_o <= line_data;
    end else if (state != ST_ALLOCATE && state_n == ST_ALLOCATE) begin
      mem_req_o  <= 1'b1;
      mem_we_o   <= 1'b0;
      mem_addr_o <= {tag, idx, {OFF_W{1'b0}}};
    end else if (state == ST_ALLOCATE && mem_ack_i) begin
      mem_req_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == ST_ALLOCATE && mem_ack_i) refill_q <= mem_rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_evt && hit_cnt_o != '1)   hit_cnt_o  <= hit_cnt_o + 1'b1;
      if (miss_evt && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a backing-memory model with configurable
// ack latency, a reference word memory for expected load data, and a second
// instance with 2-bit counters for saturation.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0, we = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic [31:0]  hit_cnt, miss_cnt;
  logic         model_ack = 1'b0, late_ack = 1'b0;

  logic         s_req = 1'b0;
  logic [31:0]  s_addr = '0;
  logic [31:0]  s_rdata;
  logic         s_stall, s_mem_req, s_mem_we;
  logic [31:0]  s_mem_addr;
  logic [255:0] s_mem_wdata;
  logic [1:0]   s_hit, s_miss;

  int unsigned  n_checks = 0, n_pass = 0;
  int unsigned  cyc = 0, cyc0 = 0, lat = 0, req_pulses = 0, wait_cnt = 0;
  logic         req_prev = 1'b0, cur_we = 1'b0;
  logic [31:0]  exp_q [$];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [31:0]  bk_mem  [logic [31:0]];

  assign mem_ack = model_ack | late_ack;

  dcache_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  dcache_ctrl #(.CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .req_i(s_req), .we_i(1'b0), .addr_i(s_addr),
    .wdata_i(32'h0), .rdata_o(s_rdata), .stall_o(s_stall),
    .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr),
    .mem_wdata_o(s_mem_wdata), .mem_rdata_i(256'h0), .mem_ack_i(s_mem_req),
    .hit_cnt_o(s_hit), .miss_cnt_o(s_miss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  function automatic logic [31:0] bk_read(input logic [31:0] a);
    if (bk_mem.exists(a)) return bk_mem[a];
    return pat(a);
  endfunction

  // Off-chip memory: ack lat cycles after a request is first seen; a request
  // that stays high after an ack is the next transaction.
  always @(negedge clk) begin
    if (rst) begin
      model_ack = 1'b0;
      wait_cnt  = 0;
      req_prev  = 1'b0;
    end else begin
      if (mem_req && !req_prev) req_pulses++;
      req_prev  = mem_req;
      model_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= lat) begin
          model_ack = 1'b1;
          wait_cnt  = 0;
          if (mem_we) begin
            for (int k = 0; k < 8; k++)
              bk_mem[mem_addr + 32'(4*k)] = mem_wdata[k*32 +: 32];
          end else begin
            for (int k = 0; k < 8; k++)
              mem_rdata[k*32 +: 32] = bk_read(mem_addr + 32'(4*k));
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called just after a posedge: drives the access and queues the expectation.
  task automatic start_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d; cur_we = w; cyc0 = cyc;
    if (w) ref_mem[{a[31:2], 2'b00}] = d;
    else   exp_q.push_back(ref_read({a[31:2], 2'b00}));
  endtask

  task automatic finish_access(input string tag, input int unsigned exp_lat);
    int unsigned n = 0;
    logic [31:0] e;
    @(negedge clk);
    while (stall && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (stall) begin
      check({tag, "_timeout"}, 64'(stall), 64'd0);
      if (!cur_we) void'(exp_q.pop_front());
    end else begin
      check({tag, "_lat"}, 64'(cyc - cyc0), 64'(exp_lat));
      if (!cur_we) begin
        e = exp_q.pop_front();
        check({tag, "_rdata"}, 64'(rdata), 64'(e));
      end
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, p0;
    repeat (2) @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_hit", 64'(hit_cnt), 64'd0);
    check("rst_miss", 64'(miss_cnt), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // 1: cold read miss, latency 3
    lat = 3;
    start_access(1'b0, 32'h40, 32'h0);
    #1 check("t1_stall_now", 64'(stall), 64'd1);
    @(posedge clk); @(negedge clk);
    check("t1_mem_req", 64'(mem_req), 64'd1);
    check("t1_mem_we", 64'(mem_we), 64'd0);
    check("t1_mem_addr", 64'(mem_addr), 64'h40);
    finish_access("t1", 6);
    check("t1_miss", 64'(miss_cnt), 64'd1);
    check("t1_hit", 64'(hit_cnt), 64'd1);

    // 2: store hit, then load it back
    start_access(1'b1, 32'h44, 32'hDEADBEEF);
    finish_access("t2_st", 0);
    start_access(1'b0, 32'h44, 32'h0);
    finish_access("t2_ld", 0);
    check("t2_hit", 64'(hit_cnt), 64'd3);

    // 3: dirty eviction to the same index
    lat = 2;
    start_access(1'b0, 32'h440, 32'h0);
    @(posedge clk); @(negedge clk);
    check("t3_wb_req", 64'(mem_req), 64'd1);
    check("t3_wb_we", 64'(mem_we), 64'd1);
    check("t3_wb_addr", 64'(mem_addr), 64'h40);
    check("t3_wb_word1", 64'(mem_wdata[63:32]), 64'hDEADBEEF);
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_alloc_addr", 64'(mem_addr), 64'h440);
    finish_access("t3", 8);
    check("t3_miss", 64'(miss_cnt), 64'd2);
    // Evicted data must come back from memory
    start_access(1'b0, 32'h44, 32'h0);
    finish_access("t3_reload", 5);

    // 4: zero-latency ack
    lat = 0;
    p0 = req_pulses;
    start_access(1'b0, 32'h1004, 32'h0);
    finish_access("t4", 3);
    check("t4_pulses", 64'(req_pulses - p0), 64'd1);
    check("t4_miss", 64'(miss_cnt), 64'd4);

    // 5: reset mid-ALLOCATE, late ack ignored
    lat = 5;
    start_access(1'b0, 32'h2008, 32'h0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_req_up", 64'(mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_req", 64'(mem_req), 64'd0);
    check("t5_rst_hit", 64'(hit_cnt), 64'd0);
    check("t5_rst_miss", 64'(miss_cnt), 64'd0);
    req = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1 late_ack = 1'b1;
    @(posedge clk); #1 late_ack = 1'b0;
    @(negedge clk);
    check("t5_late_stall", 64'(stall), 64'd0);
    check("t5_late_req", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    start_access(1'b0, 32'h2008, 32'h0);
    finish_access("t5_reread", 8);
    check("t5_miss", 64'(miss_cnt), 64'd1);
    check("t5_hit", 64'(hit_cnt), 64'd1);

    // 6: 2-bit counter saturation
    s_addr = 32'h80;
    s_req  = 1'b1;
    n = 0;
    @(negedge clk);
    while (s_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_stall_done", 64'(s_stall), 64'd0);
    check("t6_miss", 64'(s_miss), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 2) check("t6_hit_2", 64'(s_hit), 64'd2);
    end
    s_req = 1'b0;
    check("t6_hit_sat", 64'(s_hit), 64'd3);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
